// File: rtl/fib_job_scheduler_pkg.sv
// fib_sched_pkg: shared types and constants for the Fibonacci job scheduler.
//   state_t      scheduler FSM states
//   FIB_W        result width (results wrap mod 2^FIB_W)
//   N_W          width of the job index n
//   MAX_EXACT_N  largest n whose true F(n) fits in FIB_W bits
package fib_sched_pkg;

    localparam int FIB_W       = 16;
    localparam int N_W         = 5;
    localparam int MAX_EXACT_N = 24;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        START,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/fib_job_scheduler_if.sv
// fib_sched_if: request/response bundle between client blocks and the scheduler.
//   req_valid/req_n/req_ready       per-requester job handshake (req_ready one-hot)
//   resp_valid/resp_ready           result handshake
//   resp_id/resp_value/ovf/err      tagged result
// master = client side, slave = scheduler side.
interface fib_sched_if #(
    parameter int NREQ = 4
);
    import fib_sched_pkg::*;

    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0][N_W-1:0]  req_n;
    logic [NREQ-1:0]           req_ready;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [ID_W-1:0]           resp_id;
    logic [FIB_W-1:0]          resp_value;
    logic                      resp_ovf;
    logic                      resp_err;

    modport master (
        output req_valid, req_n, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_value, resp_ovf, resp_err
    );

    modport slave (
        input  req_valid, req_n, resp_ready,
        output req_ready, resp_valid, resp_id, resp_value, resp_ovf, resp_err
    );

endinterface

// File: rtl/fib_job_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first asserted request at or after
// the pointer, wrapping at NREQ.
//   i_req      request vector
//   i_ptr      highest-priority index this cycle
//   o_gnt      one-hot grant
//   o_gnt_idx  index of the granted requester
//   o_any      any request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [ID_W-1:0] o_gnt_idx,
    output logic            o_any
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_any     = 1'b0;
        o_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = ID_W'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_cand]) begin
                o_any     = 1'b1;
                o_gnt_idx = w_cand;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_gnt
        assign o_gnt[g] = o_any && (o_gnt_idx == ID_W'(g));
    end

endmodule

// File: rtl/fib_job_scheduler.sv
// fib_job_scheduler: shares one Fibonacci calculator among NREQ requesters.
// One job in flight: grant (round-robin), clear calculator, start it, wait
// for done (bounded by TIMEOUT), then present the tagged result.
//   i_clk, i_reset     clock, synchronous active-high reset
//   bus (slave)        request / response handshakes
//   o_busy             scheduler not idle
//   o_calc_reset       calculator reset (system reset or CLR state)
//   o_calc_begin       calculator start pulse
//   o_calc_n           registered job index for the calculator
//   i_calc_done        calculator done (sticky until cleared)
//   i_calc_result      calculator result
module fib_job_scheduler
    import fib_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 40
) (
    input  logic              i_clk,
    input  logic              i_reset,
    fib_sched_if.slave        bus,
    output logic              o_busy,
    output logic              o_calc_reset,
    output logic              o_calc_begin,
    output logic [N_W-1:0]    o_calc_n,
    input  logic              i_calc_done,
    input  logic [FIB_W-1:0]  i_calc_result
);

    localparam int ID_W   = $clog2(NREQ);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TMAX = TCNT_W'(TIMEOUT);

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [N_W-1:0]      r_n;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [FIB_W-1:0]    r_value;
    logic                r_ovf;
    logic                r_err;

    logic [NREQ-1:0]     w_gnt;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_any;
    logic [ID_W-1:0]     w_ptr_next;
    logic [N_W-1:0]      w_n_sel;
    logic [TCNT_W-1:0]   w_tcnt_inc;
    logic                w_timeout;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req     (bus.req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Pointer moves just past the winner; explicit wrap keeps non-power-of-2 NREQ correct.
    assign w_ptr_next = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_n_sel    = bus.req_n[w_gnt_idx];

    // Saturating counter; timeout fires on the WAIT cycle where it would reach TIMEOUT,
    // so WAIT lasts at most TIMEOUT cycles.
    assign w_tcnt_inc = (r_tcnt == TMAX) ? r_tcnt : r_tcnt + 1'b1;
    assign w_timeout  = (w_tcnt_inc == TMAX);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_state_next = (w_n_sel == '0) ? RESP : CLR;
            CLR:     w_state_next = START;
            START:   w_state_next = WAIT;
            WAIT:    if (i_calc_done || w_timeout) w_state_next = RESP;
            RESP:    if (bus.resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; all handshakes held off while reset is high.
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = 1'b0;
        o_calc_begin   = 1'b0;
        o_calc_reset   = i_reset;
        if (!i_reset) begin
            unique case (r_state)
                IDLE:    bus.req_ready  = w_gnt;
                CLR:     o_calc_reset   = 1'b1;
                START:   o_calc_begin   = 1'b1;
                RESP:    bus.resp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    // Job and result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_n     <= '0;
            r_tcnt  <= '0;
            r_value <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_n     <= w_n_sel;
                        r_id    <= w_gnt_idx;
                        r_ptr   <= w_ptr_next;
                        r_value <= '0;      // n==0 job goes straight to RESP with 0
                        r_ovf   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                START: r_tcnt <= '0;
                WAIT: begin
                    r_tcnt <= w_tcnt_inc;
                    if (i_calc_done) begin
                        r_value <= i_calc_result;
                        r_ovf   <= (r_n > N_W'(MAX_EXACT_N));
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_value <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_id    = r_id;
    assign bus.resp_value = r_value;
    assign bus.resp_ovf   = r_ovf;
    assign bus.resp_err   = r_err;
    assign o_busy         = (r_state != IDLE);
    assign o_calc_n       = r_n;

endmodule
